// File: rtl/signal_generator_multi_pkg.sv
// Shared types and time helpers for the multi-channel signal generator.
// Time values are {sec, ns} pairs with ns kept in 0..NS_PER_SEC-1.
package signal_generator_multi_pkg;

    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    localparam logic [2:0] OFF_CTRL      = 3'd0;
    localparam logic [2:0] OFF_STATUS    = 3'd1;
    localparam logic [2:0] OFF_START_SEC = 3'd2;
    localparam logic [2:0] OFF_START_NS  = 3'd3;
    localparam logic [2:0] OFF_WIDTH     = 3'd4;
    localparam logic [2:0] OFF_PERIOD    = 3'd5;
    localparam logic [2:0] OFF_REPEAT    = 3'd6;
    localparam logic [2:0] OFF_REMAIN    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } chanState_t;

    typedef struct packed {
        logic [31:0] sec;
        logic [31:0] ns;
    } timeStamp_t;

    // Both operands are below one second, so one subtract normalises.
    function automatic timeStamp_t timeAdd(
        timeStamp_t t,
        logic [31:0] dNs
    );
        timeStamp_t r;
        logic [31:0] sum;
        sum = t.ns + dNs;
        if (sum >= NS_PER_SEC) begin
            r.sec = t.sec + 32'd1;
            r.ns  = sum - NS_PER_SEC;
        end else begin
            r.sec = t.sec;
            r.ns  = sum;
        end
        return r;
    endfunction

    function automatic logic timeGeq(
        timeStamp_t a,
        timeStamp_t b
    );
        return (a.sec > b.sec) ||
               ((a.sec == b.sec) && (a.ns >= b.ns));
    endfunction

endpackage

// File: rtl/signal_generator_multi_if.sv
// Simple register bus between the AXI-lite bridge and the generator.
// Read data returns one cycle after the read strobe.
interface signal_generator_multi_if #(
    parameter int AddrWidth = 8
);
    logic                 RegWrite_EnIn;
    logic                 RegRead_EnIn;
    logic [AddrWidth-1:0] RegAddress_AdrIn;
    logic [31:0]          RegWriteData_DatIn;
    logic [31:0]          RegReadData_DatOut;
    logic                 RegReadValid_ValOut;

    modport master (
        output RegWrite_EnIn,
        output RegRead_EnIn,
        output RegAddress_AdrIn,
        output RegWriteData_DatIn,
        input  RegReadData_DatOut,
        input  RegReadValid_ValOut
    );

    modport slave (
        input  RegWrite_EnIn,
        input  RegRead_EnIn,
        input  RegAddress_AdrIn,
        input  RegWriteData_DatIn,
        output RegReadData_DatOut,
        output RegReadValid_ValOut
    );
endinterface

// File: rtl/signal_generator_multi_channel.sv
// One pulse-train channel: its register file, FSM and time datapath.
// active is the logical pulse level; polarity is applied by the top.
module signal_generator_multi_channel
    import signal_generator_multi_pkg::*;
(
    input  logic        clk,
    input  logic        rstN,
    input  timeStamp_t  nowTime,
    input  logic        timeJump,
    input  logic        timeValid,
    input  logic        wrEn,
    input  logic [2:0]  regOff,
    input  logic [31:0] wrData,
    output logic [31:0] rdData,
    output logic        active,
    output logic        irq
);

    chanState_t state, stateNext;

    logic enable, irqEn, enPrev;
    logic done, error;
    logic [31:0] startSec, startNs;
    logic [31:0] widthNs, periodNs;
    logic [31:0] repeatCnt, remainCnt;
    timeStamp_t nextT, offT;

    logic cfgOk, finite, timeBad, running;
    logic doArm, doHigh, doLow, doDone;
    logic cfgErr, timeErr;

    assign cfgOk = (startNs < NS_PER_SEC) &&
                   (widthNs != 32'd0) &&
                   (widthNs < periodNs) &&
                   (periodNs < NS_PER_SEC);
    assign finite  = (repeatCnt != 32'd0);
    assign timeBad = timeJump || !timeValid;
    assign running = (state == ST_ARMED) ||
                     (state == ST_HIGH) ||
                     (state == ST_LOW);
    assign active  = (state == ST_HIGH);
    assign irq     = irqEn && (done || error);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        doArm   = 1'b0;
        doHigh  = 1'b0;
        doLow   = 1'b0;
        doDone  = 1'b0;
        cfgErr  = 1'b0;
        timeErr = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable && !enPrev) begin
                    if (cfgOk) begin
                        stateNext = ST_ARMED;
                        doArm = 1'b1;
                    end else begin
                        cfgErr = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (timeBad) begin
                    stateNext = ST_IDLE;
                    timeErr = 1'b1;
                end else if (timeGeq(nowTime, nextT)) begin
                    stateNext = ST_HIGH;
                    doHigh = 1'b1;
                end
            end
            ST_HIGH: begin
                if (timeBad) begin
                    stateNext = ST_IDLE;
                    timeErr = 1'b1;
                end else if (timeGeq(nowTime, offT)) begin
                    stateNext = ST_LOW;
                    doLow = 1'b1;
                end
            end
            ST_LOW: begin
                if (timeBad) begin
                    stateNext = ST_IDLE;
                    timeErr = 1'b1;
                end else if (finite && remainCnt == 32'd0) begin
                    stateNext = ST_DONE;
                    doDone = 1'b1;
                end else if (timeGeq(nowTime, nextT)) begin
                    stateNext = ST_HIGH;
                    doHigh = 1'b1;
                end
            end
            ST_DONE: ;
            default: stateNext = ST_IDLE;
        endcase
        // Disabling overrides every transition and suppresses Done.
        if (!enable) begin
            stateNext = ST_IDLE;
            doArm   = 1'b0;
            doHigh  = 1'b0;
            doLow   = 1'b0;
            doDone  = 1'b0;
            cfgErr  = 1'b0;
            timeErr = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            enable    <= 1'b0;
            irqEn     <= 1'b0;
            enPrev    <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            startSec  <= '0;
            startNs   <= '0;
            widthNs   <= '0;
            periodNs  <= '0;
            repeatCnt <= '0;
            remainCnt <= '0;
            nextT     <= '0;
            offT      <= '0;
        end else begin
            enPrev <= enable;
            if (wrEn) begin
                unique case (regOff)
                    OFF_CTRL: begin
                        enable <= wrData[0];
                        irqEn  <= wrData[1];
                    end
                    OFF_STATUS: begin
                        if (wrData[0]) done  <= 1'b0;
                        if (wrData[1]) error <= 1'b0;
                    end
                    OFF_START_SEC:
                        if (!enable) startSec <= wrData;
                    OFF_START_NS:
                        if (!enable) startNs <= wrData;
                    OFF_WIDTH:
                        if (!enable) widthNs <= wrData;
                    OFF_PERIOD:
                        if (!enable) periodNs <= wrData;
                    OFF_REPEAT:
                        if (!enable) repeatCnt <= wrData;
                    default: ;
                endcase
            end
            if (doArm) begin
                nextT     <= {startSec, startNs};
                remainCnt <= repeatCnt;
            end
            if (doHigh) offT <= timeAdd(nextT, widthNs);
            if (doLow) begin
                nextT <= timeAdd(nextT, periodNs);
                if (finite) remainCnt <= remainCnt - 32'd1;
            end
            // Placed after the W1C so a same-cycle set wins.
            if (doDone) done <= 1'b1;
            if (cfgErr || timeErr) error <= 1'b1;
            if (timeErr) enable <= 1'b0;
        end
    end

    always_comb begin
        rdData = '0;
        unique case (regOff)
            OFF_CTRL:      rdData = {30'd0, irqEn, enable};
            OFF_STATUS:    rdData = {29'd0, running, error, done};
            OFF_START_SEC: rdData = startSec;
            OFF_START_NS:  rdData = startNs;
            OFF_WIDTH:     rdData = widthNs;
            OFF_PERIOD:    rdData = periodNs;
            OFF_REPEAT:    rdData = repeatCnt;
            OFF_REMAIN:    rdData = remainCnt;
            default:       rdData = '0;
        endcase
    end

endmodule

// File: rtl/signal_generator_multi.sv
// N-channel time-aligned pulse generator: address decode, registered
// read mux, IRQ merge and output polarity around the channel array.
module signal_generator_multi
    import signal_generator_multi_pkg::*;
#(
    parameter int Channels_Gen    = 4,
    parameter int ClockPeriod_Gen = 20,
    parameter logic [Channels_Gen-1:0] OutputPolarity_Gen = '1,
    parameter int AddrWidth_Gen   = 8
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRstN_RstIn,
    input  logic [31:0] ClockTime_Second_DatIn,
    input  logic [31:0] ClockTime_Nanosecond_DatIn,
    input  logic        ClockTime_TimeJump_DatIn,
    input  logic        ClockTime_ValIn,
    signal_generator_multi_if.slave regBus,
    output logic [Channels_Gen-1:0] SignalGenerator_EvtOut,
    output logic        Irq_EvtOut
);

    localparam int IdxW = AddrWidth_Gen - 3;

    if (ClockPeriod_Gen < 1 || Channels_Gen < 1 ||
        Channels_Gen > 16 || (1 << IdxW) < Channels_Gen)
    begin : gParamCheck
        $error("signal_generator_multi: bad parameters");
    end

    logic [AddrWidth_Gen-1:0] addr;
    logic [IdxW-1:0]          chanIdx;
    logic [2:0]               regOff;
    timeStamp_t               nowTime;
    logic [31:0]              chanRd [Channels_Gen];
    logic [Channels_Gen-1:0]  chanActive;
    logic [Channels_Gen-1:0]  chanIrq;
    logic [31:0]              rdMux;
    logic [31:0]              rdData;
    logic                     rdValid;

    assign addr        = regBus.RegAddress_AdrIn;
    assign chanIdx     = addr[AddrWidth_Gen-1:3];
    assign regOff      = addr[2:0];
    assign nowTime.sec = ClockTime_Second_DatIn;
    assign nowTime.ns  = ClockTime_Nanosecond_DatIn;

    for (genvar i = 0; i < Channels_Gen; i++) begin : gChan
        logic wrSel;
        assign wrSel = regBus.RegWrite_EnIn &&
                       (chanIdx == IdxW'(i));

        signal_generator_multi_channel uChan (
            .clk       (SysClk_ClkIn),
            .rstN      (SysRstN_RstIn),
            .nowTime   (nowTime),
            .timeJump  (ClockTime_TimeJump_DatIn),
            .timeValid (ClockTime_ValIn),
            .wrEn      (wrSel),
            .regOff    (regOff),
            .wrData    (regBus.RegWriteData_DatIn),
            .rdData    (chanRd[i]),
            .active    (chanActive[i]),
            .irq       (chanIrq[i])
        );
    end

    // Indices past the last channel match nothing and read as zero.
    always_comb begin
        rdMux = '0;
        for (int i = 0; i < Channels_Gen; i++) begin
            if (chanIdx == IdxW'(i)) rdMux = chanRd[i];
        end
    end

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            rdValid <= 1'b0;
            rdData  <= '0;
        end else begin
            rdValid <= regBus.RegRead_EnIn;
            if (regBus.RegRead_EnIn) rdData <= rdMux;
        end
    end

    assign regBus.RegReadData_DatOut  = rdData;
    assign regBus.RegReadValid_ValOut = rdValid;

    assign SignalGenerator_EvtOut =
        chanActive ^ ~OutputPolarity_Gen;
    assign Irq_EvtOut = |chanIrq;

endmodule
